// File: rtl/n64adv_vdemux_pkg.sv
// Shared definitions for the N64 video demultiplexer: phase encoding,
// sync-word bit positions and line-counter sizing.
package n64adv_vdemux_pkg;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_SYNC = 3'd1,
        PH_R    = 3'd2,
        PH_G    = 3'd3,
        PH_B    = 3'd4
    } phase_e;

    localparam int VSYNC_BIT = 3;
    localparam int CLAMP_BIT = 2;
    localparam int HSYNC_BIT = 1;
    localparam int CSYNC_BIT = 0;

    localparam int LINE_CNT_W = 10;
    localparam logic [LINE_CNT_W-1:0] PAL_THRESH_DEFAULT = 10'd288;
    localparam logic [LINE_CNT_W-1:0] LINE_CNT_MAX       = '1;

    function automatic logic falling(input logic prev, input logic curr);
        return prev & ~curr;
    endfunction

endpackage

// File: rtl/n64_vinfo_detect.sv
// Derives PAL/NTSC, interlace and field ID from the committed sync words by
// counting nHSYNC falling edges between nVSYNC falling edges.
module n64_vinfo_detect
    import n64adv_vdemux_pkg::*;
#(
    parameter logic [LINE_CNT_W-1:0] pal_thresh = PAL_THRESH_DEFAULT
) (
    input  logic       VCLK,
    input  logic       VRST,
    input  logic [3:0] vsync_i,
    input  logic       vdata_valid_i,
    output logic       vinfo_pal_o,
    output logic       vinfo_ilace_o,
    output logic       vinfo_field_o,
    output logic       vinfo_valid_o
);

    logic                  prev_hs_q, prev_hs_d;
    logic                  prev_vs_q, prev_vs_d;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [LINE_CNT_W-1:0] cur_cnt_q, cur_cnt_d;
    logic [LINE_CNT_W-1:0] prev_cnt_q, prev_cnt_d;
    logic                  sat_q, sat_d;
    logic [1:0]            seen_q, seen_d;
    logic                  pal_q, pal_d;
    logic                  ilace_q, ilace_d;
    logic                  field_q, field_d;
    logic                  valid_q, valid_d;

    logic                  line_evt;
    logic                  fend_evt;
    logic                  sat_evt;
    logic [LINE_CNT_W-1:0] line_cnt_inc;

    // Clamp and composite sync carry no line/field information.
    logic unused_sync_bits;
    assign unused_sync_bits = vsync_i[CLAMP_BIT] ^ vsync_i[CSYNC_BIT];

    always_comb begin
        line_evt = vdata_valid_i & falling(prev_hs_q, vsync_i[HSYNC_BIT]);
        fend_evt = vdata_valid_i & falling(prev_vs_q, vsync_i[VSYNC_BIT]);
        sat_evt  = line_evt && (line_cnt_q >= LINE_CNT_MAX - 1'b1);
        line_cnt_inc = line_cnt_q;
        if (line_evt)
            line_cnt_inc = sat_evt ? LINE_CNT_MAX : line_cnt_q + 1'b1;

        prev_hs_d  = prev_hs_q;
        prev_vs_d  = prev_vs_q;
        line_cnt_d = line_cnt_inc;
        cur_cnt_d  = cur_cnt_q;
        prev_cnt_d = prev_cnt_q;
        sat_d      = sat_q;
        seen_d     = seen_q;
        pal_d      = pal_q;
        ilace_d    = ilace_q;
        field_d    = field_q;
        valid_d    = valid_q;

        if (vdata_valid_i) begin
            prev_hs_d = vsync_i[HSYNC_BIT];
            prev_vs_d = vsync_i[VSYNC_BIT];
        end

        if (fend_evt) begin
            // A line edge in the same commit is already folded into line_cnt_inc.
            cur_cnt_d  = line_cnt_inc;
            prev_cnt_d = cur_cnt_q;
            line_cnt_d = '0;
            sat_d      = 1'b0;
            pal_d      = (line_cnt_inc >= pal_thresh);
            ilace_d    = (line_cnt_inc != cur_cnt_q);
            field_d    = ilace_d ? ~field_q : 1'b0;
            if (sat_q || sat_evt) begin
                seen_d  = 2'd0;
                valid_d = 1'b0;
            end else begin
                if (seen_q != 2'd2)
                    seen_d = seen_q + 2'd1;
                valid_d = (seen_q != 2'd0);
            end
        end else if (sat_evt) begin
            sat_d      = 1'b1;
            cur_cnt_d  = '0;
            prev_cnt_d = '0;
            seen_d     = 2'd0;
            valid_d    = 1'b0;
        end
    end

    always_ff @(posedge VCLK) begin
        if (VRST) begin
            prev_hs_q  <= 1'b1;
            prev_vs_q  <= 1'b1;
            line_cnt_q <= '0;
            cur_cnt_q  <= '0;
            prev_cnt_q <= '0;
            sat_q      <= 1'b0;
            seen_q     <= 2'd0;
            pal_q      <= 1'b0;
            ilace_q    <= 1'b0;
            field_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            prev_hs_q  <= prev_hs_d;
            prev_vs_q  <= prev_vs_d;
            line_cnt_q <= line_cnt_d;
            cur_cnt_q  <= cur_cnt_d;
            prev_cnt_q <= prev_cnt_d;
            sat_q      <= sat_d;
            seen_q     <= seen_d;
            pal_q      <= pal_d;
            ilace_q    <= ilace_d;
            field_q    <= field_d;
            valid_q    <= valid_d;
        end
    end

    // prev_cnt is kept as field history; the interlace test compares against cur_cnt_q.
    logic unused_prev_cnt;
    assign unused_prev_cnt = ^prev_cnt_q;

    assign vinfo_pal_o   = pal_q;
    assign vinfo_ilace_o = ilace_q;
    assign vinfo_field_o = field_q;
    assign vinfo_valid_o = valid_q;

endmodule

// File: rtl/n64_vdemux.sv
// Splits the registered N64 video bus into sync/R/G/B shadows and commits a
// complete pixel word one cycle after the blue component is captured.
module n64_vdemux
    import n64adv_vdemux_pkg::*;
#(
    parameter int                    color_width_i = 7,
    parameter logic [LINE_CNT_W-1:0] pal_thresh    = PAL_THRESH_DEFAULT
) (
    input  logic                     VCLK,
    input  logic                     VRST,
    input  logic                     nVDSYNC,
    input  logic [color_width_i-1:0] VD_i,
    output logic                     vdata_valid_o,
    output logic [3:0]               vsync_o,
    output logic [color_width_i-1:0] vR_o,
    output logic [color_width_i-1:0] vG_o,
    output logic [color_width_i-1:0] vB_o,
    output logic                     vinfo_pal_o,
    output logic                     vinfo_ilace_o,
    output logic                     vinfo_field_o,
    output logic                     vinfo_valid_o
);

    phase_e                   phase_q;
    logic [3:0]               sync_sh_q;
    logic [color_width_i-1:0] r_sh_q, g_sh_q, b_sh_q;
    logic [3:0]               vsync_q;
    logic [color_width_i-1:0] r_q, g_q, b_q;
    logic                     valid_q;

    always_ff @(posedge VCLK) begin
        if (VRST) begin
            phase_q   <= PH_IDLE;
            sync_sh_q <= 4'hF;
            r_sh_q    <= '0;
            g_sh_q    <= '0;
            b_sh_q    <= '0;
            vsync_q   <= 4'hF;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            // Commit is independent of nVDSYNC so a back-to-back sync word still lands the pixel.
            if (phase_q == PH_B) begin
                vsync_q <= sync_sh_q;
                r_q     <= r_sh_q;
                g_q     <= g_sh_q;
                b_q     <= b_sh_q;
                valid_q <= 1'b1;
            end

            if (!nVDSYNC) begin
                sync_sh_q <= VD_i[3:0];
                phase_q   <= PH_SYNC;
            end else begin
                case (phase_q)
                    PH_SYNC: begin
                        r_sh_q  <= VD_i;
                        phase_q <= PH_R;
                    end
                    PH_R: begin
                        g_sh_q  <= VD_i;
                        phase_q <= PH_G;
                    end
                    PH_G: begin
                        b_sh_q  <= VD_i;
                        phase_q <= PH_B;
                    end
                    default: phase_q <= PH_IDLE;
                endcase
            end
        end
    end

    assign vdata_valid_o = valid_q;
    assign vsync_o       = vsync_q;
    assign vR_o          = r_q;
    assign vG_o          = g_q;
    assign vB_o          = b_q;

    n64_vinfo_detect #(
        .pal_thresh (pal_thresh)
    ) u_vinfo (
        .VCLK          (VCLK),
        .VRST          (VRST),
        .vsync_i       (vsync_q),
        .vdata_valid_i (valid_q),
        .vinfo_pal_o   (vinfo_pal_o),
        .vinfo_ilace_o (vinfo_ilace_o),
        .vinfo_field_o (vinfo_field_o),
        .vinfo_valid_o (vinfo_valid_o)
    );

endmodule
